// File: rtl/veri_risc_pkg.sv
// Shared encodings for the parametrised VeriRISC core: opcodes, phase numbers
// and the word width derived from the address width.
package veri_risc_pkg;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  localparam logic [2:0] INST_ADDR  = 3'd0;
  localparam logic [2:0] INST_FETCH = 3'd1;
  localparam logic [2:0] INST_LOAD  = 3'd2;
  localparam logic [2:0] IDLE       = 3'd3;
  localparam logic [2:0] OP_ADDR    = 3'd4;
  localparam logic [2:0] OP_FETCH   = 3'd5;
  localparam logic [2:0] ALU_OP     = 3'd6;
  localparam logic [2:0] STORE      = 3'd7;

  function automatic int word_width(input int addr_width);
    return addr_width + 3;
  endfunction

endpackage

// File: rtl/veri_risc_core_param_if.sv
// Program-load port of the core; the host drives it while the core is frozen.
interface veri_risc_core_param_if import veri_risc_pkg::*; #(
  parameter int ADDR_WIDTH = 5
);
  localparam int WORD_WIDTH = word_width(ADDR_WIDTH);

  logic                  load_we;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [WORD_WIDTH-1:0] load_data;

  modport master (output load_we, load_addr, load_data);
  modport slave  (input  load_we, load_addr, load_data);
endinterface

// File: rtl/veri_risc_phase_ctrl.sv
// Eight-phase sequencer: advances the phase under run/halt/step control and
// decodes the register-update strobes for the clock edge leaving each phase.
module veri_risc_phase_ctrl import veri_risc_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step_mode,
  input  logic       step_go,
  input  logic [2:0] opcode,
  input  logic       acc_zero,
  output logic [2:0] phase,
  output logic       halt,
  output logic       busy,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       wr,
  output logic       skip
);
  logic [2:0] phase_nxt;
  logic       stall;
  logic       adv;

  always_ff @(posedge clk) begin
    if (rst) phase <= INST_ADDR;
    else     phase <= phase_nxt;
  end

  always_comb begin
    halt      = (phase == OP_ADDR) && (opcode == HLT);
    stall     = step_mode && (phase == INST_ADDR) && !step_go;
    adv       = run && !halt && !stall;
    phase_nxt = phase;
    if (adv) phase_nxt = phase + 3'd1;
  end

  // Strobes fire only on an advancing edge, so a frozen or stalled core never updates state.
  always_comb begin
    busy   = adv;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    wr     = 1'b0;
    skip   = 1'b0;
    case (phase)
      INST_LOAD: ld_ir  = adv;
      OP_ADDR:   inc_pc = adv;
      ALU_OP: begin
        ld_ac = adv && (opcode inside {ADD, AND, XOR, LDA});
        ld_pc = adv && (opcode == JMP);
        skip  = adv && (opcode == SKZ) && acc_zero;
      end
      STORE:     wr     = adv && (opcode == STO);
      default: ;
    endcase
  end
endmodule

// File: rtl/veri_risc_core_param.sv
// Parametrised VeriRISC CPU: datapath, ALU and unified instruction/data memory,
// sequenced by veri_risc_phase_ctrl and loadable through the load port while frozen.
module veri_risc_core_param import veri_risc_pkg::*; #(
  parameter  int ADDR_WIDTH = 5,
  localparam int WORD_WIDTH = word_width(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  step_mode,
  input  logic                  step_go,
  veri_risc_core_param_if.slave load,
  output logic                  halt,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [WORD_WIDTH-1:0] acc,
  output logic [2:0]            phase,
  output logic                  busy
);
  logic [WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [WORD_WIDTH-1:0] ir;
  logic [WORD_WIDTH-1:0] opnd_data;
  logic [WORD_WIDTH-1:0] alu;
  logic [2:0]            opcode;
  logic [ADDR_WIDTH-1:0] operand;
  logic ld_ir, inc_pc, ld_ac, ld_pc, wr, skip;

  assign opcode    = ir[WORD_WIDTH-1 -: 3];
  assign operand   = ir[ADDR_WIDTH-1:0];
  assign opnd_data = mem[operand];

  veri_risc_phase_ctrl u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .step_mode (step_mode),
    .step_go   (step_go),
    .opcode    (opcode),
    .acc_zero  (acc == '0),
    .phase     (phase),
    .halt      (halt),
    .busy      (busy),
    .ld_ir     (ld_ir),
    .inc_pc    (inc_pc),
    .ld_ac     (ld_ac),
    .ld_pc     (ld_pc),
    .wr        (wr),
    .skip      (skip)
  );

  always_comb begin
    alu = opnd_data;
    case (opcode)
      ADD:     alu = acc + opnd_data;
      AND:     alu = acc & opnd_data;
      XOR:     alu = acc ^ opnd_data;
      default: alu = opnd_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= '0;
      acc <= '0;
      ir  <= '0;
    end else begin
      if (ld_ir) ir <= mem[pc];
      // inc_pc (phase 4) and skip/ld_pc (phase 6) are never active together.
      if (inc_pc || skip) pc <= pc + 1'b1;
      else if (ld_pc)     pc <= operand;
      if (ld_ac) acc <= alu;
    end
  end

  // Memory is not reset; a load write still lands while rst is held.
  always_ff @(posedge clk) begin
    if (wr && !rst)                mem[operand]        <= acc;
    else if (!run && load.load_we) mem[load.load_addr] <= load.load_data;
  end
endmodule

// File: tb/tb_veri_risc_core_param.sv
// Directed and randomized checks of the VeriRISC core at ADDR_WIDTH 5 and 8
// against an instruction-level model kept in the bench.
module tb_veri_risc_core_param;
  logic clk = 1'b0;
  logic rst, run, step_mode, step_go;

  logic       halt_a, busy_a;
  logic [4:0] pc_a;
  logic [7:0] acc_a;
  logic [2:0] phase_a;
  logic        halt_b, busy_b;
  logic [7:0]  pc_b;
  logic [10:0] acc_b;
  logic [2:0]  phase_b;

  int n_assert = 0;
  int n_fail   = 0;
  int mem_a [32];
  int mem_b [256];

  veri_risc_core_param_if #(.ADDR_WIDTH(5)) if_a ();
  veri_risc_core_param_if #(.ADDR_WIDTH(8)) if_b ();

  veri_risc_core_param #(.ADDR_WIDTH(5)) dut_a (
    .clk(clk), .rst(rst), .run(run), .step_mode(step_mode), .step_go(step_go),
    .load(if_a), .halt(halt_a), .pc(pc_a), .acc(acc_a), .phase(phase_a), .busy(busy_a));

  veri_risc_core_param #(.ADDR_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .run(run), .step_mode(step_mode), .step_go(step_go),
    .load(if_b), .halt(halt_b), .pc(pc_b), .acc(acc_b), .phase(phase_b), .busy(busy_b));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ins(input int aw, input int op, input int opd);
    return (op << aw) | opd;
  endfunction

  task automatic load(input bit sel, input int addr, input int data);
    if (!sel) begin
      if_a.load_we = 1'b1; if_a.load_addr = addr[4:0]; if_a.load_data = data[7:0];
      mem_a[addr] = data & 'hFF;
    end else begin
      if_b.load_we = 1'b1; if_b.load_addr = addr[7:0]; if_b.load_data = data[10:0];
      mem_b[addr] = data & 'h7FF;
    end
    cyc();
    if_a.load_we = 1'b0;
    if_b.load_we = 1'b0;
  endtask

  // Instruction-level execution: 8 clocks per non-HLT instruction, HLT seen 4 clocks in.
  task automatic model_exec(input bit sel, output int hc, output int hpc, output int hacc);
    int w [256];
    int aw, am, wm, p, a, c, op, od, np;
    aw = sel ? 8 : 5;
    am = (1 << aw) - 1;
    wm = (1 << (aw + 3)) - 1;
    for (int i = 0; i <= am; i++) begin
      if (sel) w[i] = mem_b[i]; else w[i] = mem_a[i];
    end
    p = 0; a = 0; c = 0; hc = -1; hpc = 0; hacc = 0;
    for (int k = 0; k < 1000; k++) begin
      op = w[p] >> aw;
      od = w[p] & am;
      if (op == 0) begin hc = c + 4; hpc = p; hacc = a; break; end
      c += 8;
      np = (p + 1) & am;
      case (op)
        1: if (a == 0) np = (np + 1) & am;
        2: a = (a + w[od]) & wm;
        3: a = a & w[od];
        4: a = a ^ w[od];
        5: a = w[od];
        6: w[od] = a;
        default: np = od;
      endcase
      p = np;
    end
    for (int i = 0; i <= am; i++) begin
      if (sel) mem_b[i] = w[i]; else mem_a[i] = w[i];
    end
  endtask

  task automatic start();
    run = 1'b1; rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic run_to_halt(input bit sel, input int budget, output int n);
    n = 0;
    while (n < budget && !(sel ? halt_b : halt_a)) begin cyc(); n++; end
    if (!(sel ? halt_b : halt_a)) n = -1;
  endtask

  task automatic prog_check(input bit sel, input string tag);
    int hc, hpc, hacc, n;
    model_exec(sel, hc, hpc, hacc);
    start();
    run_to_halt(sel, 2000, n);
    chk({tag, "_cycles"}, n, hc);
    chk({tag, "_pc"}, sel ? pc_b : pc_a, hpc);
    chk({tag, "_acc"}, sel ? acc_b : acc_a, hacc);
    run = 1'b0;
  endtask

  initial begin
    int v, n, len;
    rst = 1'b1; run = 1'b0; step_mode = 1'b0; step_go = 1'b0;
    if_a.load_we = 1'b0; if_a.load_addr = '0; if_a.load_data = '0;
    if_b.load_we = 1'b0; if_b.load_addr = '0; if_b.load_data = '0;
    @(negedge clk);

    // Reset state, with a load write during reset.
    load(0, 0, 0);
    rst = 1'b0;
    chk("rst_phase", phase_a, 0);
    chk("rst_pc", pc_a, 0);
    chk("rst_acc", acc_a, 0);
    chk("rst_halt", halt_a, 0);
    chk("rst_busy_frozen", busy_a, 0);

    // HLT at address 0.
    start();
    repeat (3) cyc();
    chk("hlt_clk3", halt_a, 0);
    cyc();
    chk("hlt_clk4", halt_a, 1);
    chk("hlt_phase", phase_a, 4);
    chk("hlt_pc", pc_a, 0);
    chk("hlt_busy", busy_a, 0);
    repeat (10) cyc();
    chk("hlt_hold_phase", phase_a, 4);
    chk("hlt_hold_pc", pc_a, 0);
    run = 1'b0;

    // JMP / SKZ.
    load(0, 0, ins(5, 7, 2)); load(0, 1, ins(5, 7, 2)); load(0, 2, 0);
    prog_check(0, "jmp");
    load(0, 0, ins(5, 1, 0));
    prog_check(0, "skz");

    // Load/STO program; mem5 is written while rst is held.
    load(0, 0, ins(5, 5, 7)); load(0, 1, ins(5, 6, 8)); load(0, 2, ins(5, 5, 8));
    load(0, 3, ins(5, 1, 0)); load(0, 4, 0); load(0, 5, ins(5, 7, 6));
    load(0, 6, 0); load(0, 7, 1); load(0, 8, 0);
    prog_check(0, "sto");
    v = $urandom_range(1, 255);
    rst = 1'b1;
    load(0, 5, v);
    rst = 1'b0;
    load(0, 0, ins(5, 5, 5)); load(0, 1, 0);
    prog_check(0, "rst_load");

    // ADD wrap, then freeze in phase 5 with a load into the next operand.
    load(0, 0, ins(5, 5, 9)); load(0, 1, ins(5, 2, 11)); load(0, 2, ins(5, 5, 12));
    load(0, 3, 0); load(0, 9, 'hFF); load(0, 11, 1); load(0, 12, 0);
    start();
    repeat (16) cyc();
    chk("add_wrap_acc", acc_a, (255 + 1) % 256);
    repeat (5) cyc();
    chk("freeze_entry_phase", phase_a, 5);
    run = 1'b0;
    v = $urandom_range(1, 255);
    load(0, 12, v);
    repeat (4) cyc();
    chk("freeze_phase", phase_a, 5);
    chk("freeze_pc", pc_a, 3);
    chk("freeze_acc", acc_a, 0);
    chk("freeze_busy", busy_a, 0);
    run = 1'b1;
    repeat (2) cyc();
    chk("freeze_load_acc", acc_a, v);
    run_to_halt(0, 50, n);
    chk("freeze_halt_cycles", n, 1 + 4);
    run = 1'b0;

    // Step mode.
    v = $urandom_range(1, 255);
    load(0, 0, ins(5, 5, 9)); load(0, 1, ins(5, 4, 9)); load(0, 2, 0); load(0, 9, v);
    step_mode = 1'b1;
    start();
    repeat (5) cyc();
    chk("step_stall_phase", phase_a, 0);
    chk("step_stall_busy", busy_a, 0);
    chk("step_stall_pc", pc_a, 0);
    step_go = 1'b1; cyc(); step_go = 1'b0;
    chk("step_go_phase", phase_a, 1);
    chk("step_go_busy", busy_a, 1);
    repeat (7) cyc();
    chk("step1_phase", phase_a, 0);
    chk("step1_pc", pc_a, 1);
    chk("step1_acc", acc_a, v);
    chk("step1_busy", busy_a, 0);
    repeat (3) cyc();
    chk("step1_hold_phase", phase_a, 0);
    step_go = 1'b1; cyc(); step_go = 1'b0;
    repeat (7) cyc();
    chk("step2_pc", pc_a, 2);
    chk("step2_acc", acc_a, v ^ v);
    step_mode = 1'b0;
    run_to_halt(0, 50, n);
    chk("step_halt_cycles", n, 4);
    run = 1'b0;

    // Random straight-line programs, ADDR_WIDTH=5.
    for (int it = 0; it < 6; it++) begin
      for (int i = 16; i < 32; i++) load(0, i, $urandom_range(0, 255));
      len = $urandom_range(4, 10);
      for (int i = 0; i < len; i++) load(0, i, ins(5, $urandom_range(1, 6), $urandom_range(16, 31)));
      load(0, len, 0); load(0, len + 1, 0);
      prog_check(0, "rand_a");
    end

    // ADDR_WIDTH=8: far jump, pc wrap, mid-instruction reset.
    load(1, 0, ins(8, 7, 200)); load(1, 200, 0);
    prog_check(1, "w8_jmp");
    v = $urandom_range(1, 2047);
    load(1, 0, ins(8, 7, 255)); load(1, 255, ins(8, 5, 10)); load(1, 10, v);
    start();
    repeat (12) cyc();
    chk("w8_pc_255", pc_b, 255);
    cyc();
    chk("w8_pc_wrap", pc_b, 0);
    repeat (2) cyc();
    chk("w8_acc", acc_b, v);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("w8_rst_phase", phase_b, 0);
    chk("w8_rst_pc", pc_b, 0);
    chk("w8_rst_acc", acc_b, 0);
    chk("w8_rst_halt", halt_b, 0);
    run = 1'b0;
    for (int it = 0; it < 2; it++) begin
      for (int i = 128; i < 144; i++) load(1, i, $urandom_range(0, 2047));
      len = $urandom_range(4, 10);
      for (int i = 0; i < len; i++) load(1, i, ins(8, $urandom_range(1, 6), $urandom_range(128, 143)));
      load(1, len, 0); load(1, len + 1, 0);
      prog_check(1, "rand_b");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
